// File: rtl/serial_pattern_pkg.sv
// Shared types, constants and the expected-bit rule for the serial pattern
// checker and its matching transmit-side generator.
package serial_pattern_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PRBS7  = 1'b1;

  localparam int PRBS_LEN   = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;

  // sr[0] holds the newest bit, sr[6] the bit seven positions back.
  function automatic logic next_exp(input logic [PRBS_LEN-1:0] sr, input logic mode);
    if (mode == MODE_PRBS7) begin
      return sr[PRBS_TAP_A] ^ sr[PRBS_TAP_B];
    end
    return ~sr[0];
  endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// 7-bit shift register for x^7+x^6+1: parallel load, or shift in either the
// LFSR feedback or an externally chosen bit.
module prbs7_lfsr
  import serial_pattern_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PRBS_LEN-1:0] load_val,
  input  logic                shift,
  input  logic                ext_sel,
  input  logic                ext_bit,
  output logic [PRBS_LEN-1:0] sr
);

  logic [PRBS_LEN-1:0] sr_q, sr_d;
  logic                fb;
  logic                in_bit;

  always_comb begin
    fb     = sr_q[PRBS_TAP_A] ^ sr_q[PRBS_TAP_B];
    in_bit = ext_sel ? ext_bit : fb;
    sr_d   = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = {sr_q[PRBS_LEN-2:0], in_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr = sr_q;

endmodule

// File: rtl/serial_pattern_checker.sv
// Receive-side checker for toggle / PRBS7 serial streams: self-synchronises in
// HUNT, then flywheels in LOCKED and counts bit errors.
module serial_pattern_checker
  import serial_pattern_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSE_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             clr,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] LOSE_LAST = 8'(LOSE_CNT - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [2:0]         fill_q, fill_d;
  logic [7:0]         good_q, good_d;
  logic [7:0]         bad_q, bad_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_pulse_q, err_pulse_d;

  logic [PRBS_LEN-1:0] sr;
  logic                sr_load, sr_shift, sr_bit;
  logic                exp_bit;
  logic [2:0]          fill_need;

  prbs7_lfsr u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sr_load),
    .load_val ('0),
    .shift    (sr_shift),
    .ext_sel  (1'b1),
    .ext_bit  (sr_bit),
    .sr       (sr)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode;
    fill_d      = fill_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_bit      = data_in;
    exp_bit     = next_exp(sr, mode_q);
    fill_need   = (mode_q == MODE_PRBS7) ? 3'(PRBS_LEN) : 3'd1;

    // A mode change discards the current bit and restarts acquisition.
    if (mode != mode_q) begin
      state_d = HUNT;
      fill_d  = '0;
      good_d  = '0;
      bad_d   = '0;
      sr_load = 1'b1;
    end else if (data_valid) begin
      case (state_q)
        HUNT: begin
          sr_shift = 1'b1;
          sr_bit   = data_in;
          if (fill_q < fill_need) begin
            fill_d = fill_q + 3'd1;
          end else if (data_in == exp_bit) begin
            if (good_q == LOCK_LAST) begin
              state_d = LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 8'd1;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: history follows the prediction, not the line.
          sr_shift = 1'b1;
          sr_bit   = exp_bit;
          if (data_in == exp_bit) begin
            bad_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (bad_q == LOSE_LAST) begin
              state_d = HUNT;
              fill_d  = '0;
              good_d  = '0;
              bad_d   = '0;
              sr_load = 1'b1;
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      mode_q      <= MODE_TOGGLE;
      fill_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_serial_pattern_checker.sv
// Randomised self-checking bench for serial_pattern_checker; a 16-bit and a
// 4-bit error-counter instance run side by side against a queue-based model.
module tb_serial_pattern_checker;

  localparam int LOCK_CNT = 8;
  localparam int LOSE_CNT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mode = 1'b0;
  logic clr = 1'b0;
  logic data_valid = 1'b0;
  logic data_in = 1'b0;

  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;

  int checks = 0;
  int errors = 0;

  // Behavioural model: received history as a queue, newest bit at the back.
  logic m_mode, m_locked, m_pulse;
  int   m_good, m_bad, m_err, m_err4;
  bit   hist[$];
  bit   prbs_seq[127];
  int   p_idx = 0;
  bit   tog_bit = 1'b0;

  serial_pattern_checker #(.LOCK_CNT(LOCK_CNT), .LOSE_CNT(LOSE_CNT), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clr(clr), .data_valid(data_valid),
    .data_in(data_in), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  serial_pattern_checker #(.LOCK_CNT(LOCK_CNT), .LOSE_CNT(LOSE_CNT), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clr(clr), .data_valid(data_valid),
    .data_in(data_in), .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 1'b0; m_locked = 1'b0; m_pulse = 1'b0;
    m_good = 0; m_bad = 0; m_err = 0; m_err4 = 0;
    hist.delete();
  endfunction

  function automatic bit model_exp();
    if (m_mode) return hist[hist.size()-7] ^ hist[hist.size()-6];
    return ~hist[hist.size()-1];
  endfunction

  function automatic void model_edge();
    bit e;
    int need;
    m_pulse = 1'b0;
    need = m_mode ? 7 : 1;
    if (mode !== m_mode) begin
      m_mode = mode; m_locked = 1'b0; hist.delete(); m_good = 0; m_bad = 0;
    end else if (data_valid) begin
      if (!m_locked) begin
        if (hist.size() < need) begin
          hist.push_back(data_in);
        end else begin
          e = model_exp();
          if (data_in == e) begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_locked = 1'b1; m_bad = 0; end
          end else begin
            m_good = 0;
          end
          hist.push_back(data_in);
        end
      end else begin
        e = model_exp();
        hist.push_back(e);
        if (data_in == e) begin
          m_bad = 0;
        end else begin
          m_pulse = 1'b1;
          if (m_err < 65535) m_err++;
          if (m_err4 < 15) m_err4++;
          m_bad++;
          if (m_bad == LOSE_CNT) begin
            m_locked = 1'b0; hist.delete(); m_good = 0; m_bad = 0;
          end
        end
      end
    end
    if (clr) begin m_err = 0; m_err4 = 0; end
    if (hist.size() > 16) void'(hist.pop_front());
  endfunction

  function automatic logic [23:0] obs_vec();
    return {locked, err_pulse, err_cnt, locked4, err_pulse4, err_cnt4};
  endfunction

  function automatic logic [23:0] exp_vec();
    return {m_locked, m_pulse, 16'(m_err), m_locked, m_pulse, 4'(m_err4)};
  endfunction

  // Next correct source bit for the current mode.
  function automatic bit src_next();
    bit b;
    if (mode) begin
      b = prbs_seq[p_idx];
      p_idx = (p_idx + 1) % 127;
    end else begin
      tog_bit = ~tog_bit;
      b = tog_bit;
    end
    return b;
  endfunction

  task automatic step(input logic v, input logic d, input logic c);
    data_valid = v; data_in = d; clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_valid = 1'b1; data_in = 1'b0;
    model_reset();
    for (int t = 0; t < 2; t++) begin
      #1;
      data_in = ~data_in;
      checks++;
      if (obs_vec() !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold t=%0t: got %h expected 000000", $time, obs_vec());
      end
    end
    #1;
    data_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if ($isunknown(obs_vec()) || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    $display("test_reset: outputs held at zero through and after reset");
  endtask

  task automatic test_toggle_lock();
    int lock_at = 0;
    mode = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step(1'b1, src_next(), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL toggle_lock bit %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (lock_at == 0 && locked === 1'b1) lock_at = i;
    end
    checks++;
    if (lock_at != 9) begin
      errors++;
      $display("FAIL toggle_lock_point: got bit %0d expected bit 9", lock_at);
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL toggle_err_cnt: got %0d expected 0", err_cnt);
    end
    $display("test_toggle_lock: locked at valid bit %0d", lock_at);
  endtask

  task automatic test_single_error();
    int pulses = 0;
    for (int i = 0; i < 22; i++) begin
      step(1'b1, (i == 0) ? ~src_next() : src_next(), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_error step %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_error_summary: got pulses=%0d cnt=%0d locked=%b expected 1/1/1",
               pulses, err_cnt, locked);
    end
    $display("test_single_error: pulses=%0d err_cnt=%0d", pulses, err_cnt);
  endtask

  task automatic test_loss_of_lock();
    int relock = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, ~src_next(), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || locked !== (k < 4)) begin
        errors++;
        $display("FAIL loss_corrupt %0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (err_cnt !== 16'd4) begin
      errors++;
      $display("FAIL loss_err_cnt: got %0d expected 4", err_cnt);
    end
    for (int i = 1; i <= 40 && relock == 0; i++) begin
      step(1'b1, src_next(), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL relock bit %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (locked === 1'b1) relock = i;
    end
    checks++;
    if (relock != 9 || err_cnt !== 16'd4) begin
      errors++;
      $display("FAIL relock_point: got bit %0d cnt %0d expected bit 9 cnt 4", relock, err_cnt);
    end
    $display("test_loss_of_lock: relocked after %0d valid bits", relock);
  endtask

  task automatic test_prbs();
    int cyc = 0, nvalid = 0, lock_at = 0, pulses = 0, flip_at;
    bit b, v;
    logic prev_locked;
    logic [15:0] prev_cnt;
    mode = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || err_cnt !== 16'd4 || locked !== 1'b0) begin
      errors++;
      $display("FAIL prbs_mode_change: got %h expected %h", obs_vec(), exp_vec());
    end
    flip_at = 25 + $urandom_range(0, 10);
    while (nvalid < flip_at + 20 && cyc < 200) begin
      v = (cyc % 3) != 2;
      cyc++;
      b = 1'b0;
      if (v) begin
        b = src_next();
        nvalid++;
        if (nvalid == flip_at) b = ~b;
      end
      prev_locked = locked;
      prev_cnt = err_cnt;
      step(v, b, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL prbs cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      if (!v) begin
        checks++;
        if (locked !== prev_locked || err_cnt !== prev_cnt || err_pulse !== 1'b0) begin
          errors++;
          $display("FAIL prbs_idle cyc %0d: got locked=%b cnt=%0d pulse=%b expected %b/%0d/0",
                   cyc, locked, err_cnt, err_pulse, prev_locked, prev_cnt);
        end
      end
      if (lock_at == 0 && locked === 1'b1) lock_at = nvalid;
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (lock_at != 15 || pulses != 1 || err_cnt !== 16'd5 || locked !== 1'b1) begin
      errors++;
      $display("FAIL prbs_summary: got lock_at=%0d pulses=%0d cnt=%0d locked=%b expected 15/1/5/1",
               lock_at, pulses, err_cnt, locked);
    end
    $display("test_prbs: locked at valid bit %0d, error flipped at bit %0d", lock_at, flip_at);
  endtask

  task automatic test_saturation();
    int gap;
    for (int e = 0; e < 20; e++) begin
      step(1'b1, ~src_next(), 1'b0);
      gap = $urandom_range(1, 3);
      for (int g = 0; g <= gap; g++) begin
        if (g > 0) step(1'b1, src_next(), 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL saturation err %0d: got %h expected %h", e, obs_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (err_cnt4 !== 4'd15 || err_cnt !== 16'd25 || locked4 !== 1'b1) begin
      errors++;
      $display("FAIL saturation_summary: got cnt4=%0d cnt=%0d locked4=%b expected 15/25/1",
               err_cnt4, err_cnt, locked4);
    end
    $display("test_saturation: err_cnt4=%0d err_cnt=%0d", err_cnt4, err_cnt);
  endtask

  task automatic test_clr_coincident();
    step(1'b1, ~src_next(), 1'b1);
    checks++;
    if (err_cnt !== 16'd0 || err_cnt4 !== 4'd0 || err_pulse !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL clr_coincident: got %h expected %h", obs_vec(), exp_vec());
    end
    step(1'b1, src_next(), 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL clr_after: got %h expected %h", obs_vec(), exp_vec());
    end
    $display("test_clr_coincident: err_cnt cleared with pulse");
  endtask

  task automatic test_random_soak();
    bit v, b, c;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      v = $urandom_range(0, 3) != 0;
      b = v ? src_next() : 1'b0;
      if (v && $urandom_range(0, 15) == 0) b = ~b;
      c = $urandom_range(0, 39) == 0;
      step(v, b, c);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL soak cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    $display("test_random_soak: 600 cycles, final err_cnt=%0d", err_cnt);
  endtask

  task automatic test_reset_midop();
    int n = 0;
    while (locked !== 1'b1 && n < 300) begin
      step(1'b1, src_next(), 1'b0);
      n++;
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL midop_lock_timeout: got locked=%b expected 1", locked);
    end
    step(1'b1, ~src_next(), 1'b0);
    #2;
    rst_n = 1'b0;
    data_valid = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== 24'h0) begin
      errors++;
      $display("FAIL midop_reset_immediate: got %h expected 000000", obs_vec());
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== 24'h0) begin
      errors++;
      $display("FAIL midop_reset_hold: got %h expected 000000", obs_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, src_next(), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midop_restart %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    $display("test_reset_midop: reset while locked, restart locked=%b", locked);
  endtask

  initial begin
    for (int n = 0; n < 7; n++) prbs_seq[n] = 1'b1;
    for (int n = 7; n < 127; n++) prbs_seq[n] = prbs_seq[n-7] ^ prbs_seq[n-6];
    test_reset();
    test_toggle_lock();
    test_single_error();
    test_loss_of_lock();
    test_prbs();
    test_saturation();
    test_clr_coincident();
    test_random_soak();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
